instr_fetch_queue: RTL
======================

# instr_fetch_queue

Instruction fetch queue between the IF2 bundle register and the decode stage. Each cycle it accepts one fetch group of sparse instruction bundles and compacts the valid ones, in order, into a circular buffer. It then presents up to OUT_W oldest bundles per cycle to decode, which consumes a variable number of them. Stall and flush control toward fetch and decode is handled here, and per-group fetch exceptions are carried with each entry.

## Interface
- IN_W, 8: bundles per input fetch group (equals `FETCH_RATE_HW`).
- OUT_W, 4: bundles presented to decode per cycle.
- DEPTH, 16: queue entries. Power of 2, ≥ IN_W.
- BLEN, `BUNDLE_LEN`: bundle width; the valid bit is at `BUNDLE_VALID`.
- ELEN, `ECAUSE_LEN`: exception-cause width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- Flush  in  1  synchronous queue flush (redirect).
- In_Valid  in  1  fetch group offered this cycle.
- In_Bundles  in  IN_W*BLEN  fetch group. Bundle i is at [(i+1)*BLEN-1 : i*BLEN].
- In_Exception  in  1  fetch exception for the whole group.
- In_Ecause  in  ELEN  exception cause.
- In_Ready  out  1  queue can absorb a full group (free entries ≥ IN_W).
- Out_Bundles  out  OUT_W*BLEN  oldest entries; slot 0 is the oldest.
- Out_Exception  out  OUT_W  per-slot exception flag.
- Out_Ecause  out  OUT_W*ELEN  per-slot cause.
- Out_Count  out  clog2(OUT_W+1)  number of valid output slots.
- Dec_Accept  in  clog2(OUT_W+1)  number of entries decode consumes this cycle.

## Operation
**Storage**
- DEPTH entries, each holding {bundle, exc, ecause}.
- State: head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits).

**Enqueue** (fire when In_Valid & In_Ready)
- Let m = number of In_Bundles with the valid bit set. m ranges 0..IN_W.
- Write the valid bundles in ascending index order to tail, tail+1, … tail+m-1 (modulo DEPTH).
- Invalid bundles are skipped.
- Stored exc = In_Exception and ecause = In_Ecause on every entry written.
- If m = 0 and In_Exception = 1, write one entry: bundle 0 with its valid bit forced to 1, exc = 1. This makes the exception reach decode.
- If m = 0 and In_Exception = 0, nothing is written.
- tail += entries written.

**Dequeue**
- Out_Count = min(count, OUT_W).
- Slot k drives the entry at head+k for k < Out_Count.
- Slots k ≥ Out_Count drive all-zero bundle, exc and ecause.
- Effective accept a = min(Dec_Accept, Out_Count); any excess is ignored.
- head += a.

**Count**
- count_next = count + written − a.
- Enqueue and dequeue in the same cycle are both honoured.
- In_Ready = (DEPTH − count) ≥ IN_W, derived from registered count only. It is independent of Dec_Accept, so there is no combinational path from decode to fetch.

**Flush and reset**
- Priority: rst > Flush > normal operation.
- Either one sets head, tail and count to 0.
- The concurrent input group and Dec_Accept are discarded.
- Storage contents need not be cleared; outputs are masked by count.

## Timing
- All state updates on posedge clk.
- Out_* are combinational from registered state. There is no input-to-output bypass.
- A bundle enqueued at edge N is visible on Out_Bundles in the cycle after edge N (latency 1 when the queue is empty).
- Values after reset:
  - Out_Count = 0.
  - Out_Bundles = 0, Out_Exception = 0, Out_Ecause = 0.
  - In_Ready = 1.
- The same values hold in the cycle following a Flush.
- Boundary conditions:
  - **Full:** count = DEPTH is reachable only when IN_W divides the free space; In_Ready = 0 there.
  - **Empty:** Out_Count = 0, and any Dec_Accept is ignored.
  - **Wrap:** enqueue and dequeue windows may straddle entry DEPTH−1 → 0; order is preserved.
- The fetch side must hold In_* stable while In_Valid & ~In_Ready. Those groups are neither consumed nor dropped.

## Test plan
Configuration for all cases: IN_W=8, OUT_W=4, DEPTH=16.

1. **Reset:** assert rst 2 cycles with In_Valid=1 → Out_Count=0, Out_Bundles=0, In_Ready=1; queue stays empty after release.
2. **Compaction:** empty queue, one group with valid mask 8'b1011_0101, Dec_Accept=0 → next cycle Out_Count=4, slots 0..3 = bundles 0,2,4,5; after Dec_Accept=4, Out_Count=1 with slot 0 = bundle 7.
3. **Backpressure:**
   - Two groups of 8 valid each with Dec_Accept=0 → count 16, In_Ready=0; a third group is held and not enqueued.
   - Dec_Accept=4 → count 12, In_Ready stays 0.
   - Dec_Accept=4 again → count 8, In_Ready=1.
4. **Wrap and concurrency:**
   - Advance pointers to head=tail=14.
   - Enqueue 5 valid bundles while count=0 → entries 14,15,0,1,2.
   - Next cycle, Dec_Accept=4 with a concurrent 3-bundle group → count 4; order matches input order.
5. **Accept clamp:** count=2, Dec_Accept=4 → a=2, count 0, Out_Count=0 next cycle, no pointer overrun.
6. **Flush and exception:**
   - Flush with count=9, In_Valid=1 and Dec_Accept=3 → next cycle Out_Count=0, In_Ready=1.
   - Then a group with mask 0 and In_Exception=1, cause 12 → one entry: Out_Count=1, Out_Exception[0]=1, Out_Ecause slot 0=12.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: compacts sparse fetch groups into a circular buffer and presents the oldest bundles to decode.
module instr_fetch_queue #(
  parameter int IN_W = 8,
  parameter int OUT_W = 4,
  parameter int DEPTH = 16,
  parameter int BLEN = 32,
  parameter int VBIT = BLEN - 1,
  parameter int ELEN = 6,
  localparam int AW = $clog2(DEPTH),
  localparam int CNT_W = AW + 1,
  localparam int CW = $clog2(OUT_W + 1),
  localparam int PW = $clog2(IN_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Flush,
  input  logic                  In_Valid,
  input  logic [IN_W*BLEN-1:0]  In_Bundles,
  input  logic                  In_Exception,
  input  logic [ELEN-1:0]       In_Ecause,
  output logic                  In_Ready,
  output logic [OUT_W*BLEN-1:0] Out_Bundles,
  output logic [OUT_W-1:0]      Out_Exception,
  output logic [OUT_W*ELEN-1:0] Out_Ecause,
  output logic [CW-1:0]         Out_Count,
  input  logic [CW-1:0]         Dec_Accept
);
  logic [BLEN-1:0] bun_q [DEPTH];
  logic [ELEN-1:0] ec_q [DEPTH];
  logic [DEPTH-1:0] exc_q;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IN_W-1:0] v;
  logic [PW-1:0] pos [IN_W];
  logic [PW-1:0] m, wr;
  logic [CW-1:0] oc, acc;
  logic fire, xonly;
  for (genvar i = 0; i < IN_W; i++) begin : g_v
    assign v[i] = In_Bundles[i*BLEN+VBIT];
  end
  // pos[i] is the compacted slot offset of bundle i within the group
  assign pos[0] = '0;
  for (genvar i = 1; i < IN_W; i++) begin : g_p
    assign pos[i] = pos[i-1] + PW'(v[i-1]);
  end
  assign m = pos[IN_W-1] + PW'(v[IN_W-1]);
  assign In_Ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_W);
  assign fire = In_Valid & In_Ready;
  assign xonly = fire & (m == '0) & In_Exception;
  assign wr = fire ? (xonly ? PW'(1) : m) : '0;
  assign oc = (count_q >= CNT_W'(OUT_W)) ? CW'(OUT_W) : CW'(count_q);
  assign acc = (Dec_Accept > oc) ? oc : Dec_Accept;
  assign head_d = head_q + AW'(acc);
  assign tail_d = tail_q + AW'(wr);
  assign count_d = count_q + CNT_W'(wr) - CNT_W'(acc);
  assign Out_Count = oc;
  always_ff @(posedge clk) begin
    if (rst | Flush) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // An exception-only group still occupies one entry so the fault reaches decode
  always_ff @(posedge clk) begin
    if (!rst && !Flush && fire) begin
      for (int i = 0; i < IN_W; i++)
        if (v[i]) begin
          bun_q[tail_q + AW'(pos[i])] <= In_Bundles[i*BLEN +: BLEN];
          exc_q[tail_q + AW'(pos[i])] <= In_Exception;
          ec_q[tail_q + AW'(pos[i])] <= In_Ecause;
        end
      if (xonly) begin
        bun_q[tail_q] <= In_Bundles[BLEN-1:0] | (BLEN'(1) << VBIT);
        exc_q[tail_q] <= 1'b1;
        ec_q[tail_q] <= In_Ecause;
      end
    end
  end
  for (genvar k = 0; k < OUT_W; k++) begin : g_o
    logic [AW-1:0] idx;
    logic on;
    assign idx = head_q + AW'(k);
    assign on = CW'(k) < oc;
    assign Out_Bundles[k*BLEN +: BLEN] = on ? bun_q[idx] : '0;
    assign Out_Exception[k] = on & exc_q[idx];
    assign Out_Ecause[k*ELEN +: ELEN] = on ? ec_q[idx] : '0;
  end
endmodule
